// File: rtl/ysyx_22050535_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22050535_ifu -- instruction fetch stage
//
// Holds the PC, issues one instruction-memory read at a time and hands
// {inst, pc} to decode through a one-entry output buffer. A redirect from
// execute reloads the PC (word aligned) and causes any fetch already in
// flight to be thrown away when its response comes back.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   imem_req_*      fetch request: valid/ready, addr = current pc
//   imem_rsp_*      fetch response: valid only, one per accepted request
//   redirect_*      single-cycle PC redirect from execute
//   out_*           {out_inst, out_pc} to decode, valid/ready
//   o_dbg_state     current FSM state, for observation only
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both high; the sender keeps valid and
// its payload stable until that edge, the receiver may drive ready freely.
// ----------------------------------------------------------------------------
module ysyx_22050535_ifu #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_drop;      // the outstanding response is stale
    logic [INST_W-1:0] r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;

    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_unused_bits;

    // Instructions are word aligned; the low target bits are ignored.
    assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_bits = ^redirect_pc[1:0];

    // A redirect cycle never issues a request: the pc is about to change.
    assign imem_req_valid = (r_state == S_REQ) && !redirect_valid;
    assign imem_req_addr  = r_pc;
    assign out_valid      = (r_state == S_HOLD);
    assign out_inst       = r_out_inst;
    assign out_pc         = r_out_pc;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_out_inst <= '0;
            r_out_pc   <= '0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            case (r_state)
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        // The response landing now is the stale one; it is
                        // consumed here, so nothing is left to drop.
                        r_drop  <= 1'b0;
                        r_state <= S_REQ;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Buffer flushed; a same-cycle out_ready still transfers.
                    r_state <= S_REQ;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_out_inst <= imem_rsp_data;
                            r_out_pc   <= r_pc;
                            r_pc       <= r_pc + ADDR_W'(4);
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050535_ifu.sv
// Testbench for ysyx_22050535_ifu: directed scenarios followed by random
// traffic, checked against a transaction-level model of the fetch stage.
module tb_ysyx_22050535_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  dbg_state;

    ysyx_22050535_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];      // {inst, pc} expected at decode, in order
    int          n_checks = 0;
    int          n_pass   = 0;

    // ---------------- reference model ----------------
    // pc_m     : address the next fetch must use
    // busy     : a request has been accepted and its response not yet seen
    // stale    : that outstanding response belongs to a pre-redirect fetch
    // occupied : one instruction is waiting for decode
    logic [31:0] pc_m;
    logic        busy;
    logic        stale;
    logic        occupied;
    logic [31:0] req_addr;
    logic [31:0] mem_data;
    int          delay;
    int          lat_cfg;       // <0: random memory latency

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        pc_m     = RESET_PC;
        busy     = 1'b0;
        stale    = 1'b0;
        occupied = 1'b0;
        delay    = 0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
    endtask

    // Reset asserted mid-cycle; its effect must be visible immediately.
    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check request/valid signals, advance model.
    task automatic step(input logic rr, input logic orr, input logic rd, input logic [31:0] rpc);
        logic rsp;
        logic exp_req;
        @(negedge clk);
        imem_req_ready = rr;
        out_ready      = orr;
        redirect_valid = rd;
        redirect_pc    = rpc;
        rsp            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (busy) begin
            if (delay == 0) begin
                rsp            = 1'b1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data;
            end else begin
                delay--;
            end
        end else if ($urandom_range(0, 19) == 0) begin
            imem_rsp_valid = 1'b1;   // spurious response, must be ignored
        end
        #1;
        exp_req = !busy && !occupied && !rd;
        check("req_valid", imem_req_valid, exp_req);
        if (exp_req) check("req_addr", imem_req_addr, pc_m);
        check("out_valid", out_valid, occupied);
        #1;
        if (rd) begin
            pc_m = {rpc[31:2], 2'b00};
            if (busy) begin
                if (rsp) begin
                    busy  = 1'b0;
                    stale = 1'b0;
                end else begin
                    stale = 1'b1;
                end
            end
            if (occupied) begin
                if (!orr && exp_q.size() > 0) void'(exp_q.pop_back());
                occupied = 1'b0;
            end
        end else if (busy) begin
            if (rsp) begin
                busy = 1'b0;
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    exp_q.push_back({mem_data, req_addr});
                    pc_m     = req_addr + 32'd4;
                    occupied = 1'b1;
                end
            end
        end else if (occupied) begin
            if (orr) occupied = 1'b0;
        end else if (rr) begin
            busy     = 1'b1;
            req_addr = pc_m;
            mem_data = $urandom;
            delay    = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        end
    endtask

    // ---------------- monitor ----------------
    // Whatever decode sees must be the oldest expected entry, held stable
    // until it is taken.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", {out_inst, out_pc}, 64'h0);
                end else begin
                    check("out_data", {out_inst, out_pc}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive_idle();
        lat_cfg = 0;
        model_reset();
        do_reset();

        // first fetch with next-cycle response, then decode stalls 5 cycles
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // redirect while waiting; stale response arrives later
        lat_cfg = 2;
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h8000_0103);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);

        // redirect in the same cycle as the response
        lat_cfg = 0;
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h8000_0200);

        // redirects in S_REQ with memory ready, last one wins
        step(1, 1, 1, 32'h8000_0300);
        step(1, 1, 1, 32'hFFFF_FFFE);

        // fetch at FFFF_FFFC, pc wraps to 0
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);

        // reset mid-fetch
        lat_cfg = 3;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        do_reset();

        // reset while holding an instruction for decode
        lat_cfg = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        do_reset();

        // random traffic
        lat_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 11) == 0,
                 $urandom);
        end
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
